decimal_value_entry: RTL and testbench

- Operator-input counterpart to the 4-digit seven-segment display path: turns push-button presses into a 4-digit decimal value, then converts it to 16-bit binary.
- Feeds the servo PWM pulse-width register (value in microseconds).
- Exposes its live BCD digits and cursor position so the display driver can echo the value as it is edited.
- Performs a sequential BCD-to-binary conversion on commit, with a one-cycle valid pulse.

---
 rtl/decimal_value_entry_pkg.sv | 34 +++
 rtl/decimal_value_entry_if.sv | 28 ++
 rtl/decimal_value_entry_tick_edge_detect.sv | 22 ++
 rtl/decimal_value_entry.sv | 118 +++++++++++
 tb/tb_decimal_value_entry.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decimal_value_entry_pkg.sv
// Shared types and helpers for the push-button decimal entry block.
// Holds the FSM state encoding, BCD digit vector type and button index map.
package decimal_entry_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_BTNS   = 4;

    // Bit positions of each button in the sampled/press vectors
    localparam int BTN_SEL    = 0;
    localparam int BTN_INC    = 1;
    localparam int BTN_DEC    = 2;
    localparam int BTN_COMMIT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        CLAMP = 2'd2
    } state_t;

    typedef logic [NUM_DIGITS-1:0][3:0] bcd_digits_t;

    // Elaboration-time conversion, used for the reset digit image
    function automatic bcd_digits_t to_bcd(input int unsigned value);
        bcd_digits_t d;
        int unsigned v;
        v = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d[i] = 4'(v % 10);
            v    = v / 10;
        end
        return d;
    endfunction

endpackage

// File: rtl/decimal_value_entry_if.sv
// Button inputs and value/echo outputs of the decimal entry block.
// master drives buttons and observes results; slave is the entry block itself.
interface decimal_value_entry_if;
    import decimal_entry_pkg::*;

    logic        tick;
    logic        btn_sel;
    logic        btn_inc;
    logic        btn_dec;
    logic        btn_commit;
    bcd_digits_t digits_bcd;
    logic [1:0]  cursor;
    logic        busy;
    logic [15:0] value_out;
    logic        value_valid;
    logic        value_clamped;

    modport master (
        output tick, btn_sel, btn_inc, btn_dec, btn_commit,
        input  digits_bcd, cursor, busy, value_out, value_valid, value_clamped
    );

    modport slave (
        input  tick, btn_sel, btn_inc, btn_dec, btn_commit,
        output digits_bcd, cursor, busy, value_out, value_valid, value_clamped
    );

endinterface

// File: rtl/decimal_value_entry_tick_edge_detect.sv
// Per-button sampler: remembers the level seen at the previous tick and
// flags a press only on a tick where the button is newly high.
module tick_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic press
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n)
            prev <= 1'b0;
        else if (tick)
            prev <= btn;
    end

    assign press = tick & btn & ~prev;

endmodule

// File: rtl/decimal_value_entry.sv
// Four-digit BCD editor driven by push buttons; on commit the digits are
// folded into binary one digit per cycle, clamped, and published with a pulse.
module decimal_value_entry
    import decimal_entry_pkg::*;
#(
    parameter int unsigned MAX_VALUE     = 9999,
    parameter int unsigned MIN_VALUE     = 0,
    parameter int unsigned DEFAULT_VALUE = 1500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decimal_value_entry_if.slave  bus
);

    localparam bcd_digits_t RST_DIGITS = to_bcd(DEFAULT_VALUE);
    localparam logic [15:0] MAX_V      = 16'(MAX_VALUE);
    localparam logic [15:0] MIN_V      = 16'(MIN_VALUE);
    localparam logic [15:0] DEF_V      = 16'(DEFAULT_VALUE);

    logic [NUM_BTNS-1:0] btn;
    logic [NUM_BTNS-1:0] press;

    state_t      state;
    bcd_digits_t digits;
    logic [1:0]  cursor;
    logic [1:0]  idx;
    logic [15:0] acc;
    logic [15:0] value_q;
    logic        valid_q;
    logic        clamped_q;
    logic        busy_q;
    logic        below_min;

    assign btn = {bus.btn_commit, bus.btn_dec, bus.btn_inc, bus.btn_sel};

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        tick_edge_detect u_det (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (bus.tick),
            .btn   (btn[g]),
            .press (press[g])
        );
    end

    // A zero lower bound can never be undercut; skip the always-false compare
    if (MIN_VALUE > 0) begin : g_min
        assign below_min = (acc < MIN_V);
    end else begin : g_nomin
        assign below_min = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            digits    <= RST_DIGITS;
            cursor    <= 2'd0;
            idx       <= 2'd0;
            acc       <= 16'd0;
            value_q   <= DEF_V;
            valid_q   <= 1'b0;
            clamped_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (press[BTN_COMMIT]) begin
                        acc    <= 16'd0;
                        idx    <= 2'd3;
                        busy_q <= 1'b1;
                        state  <= CONV;
                    end else if (press[BTN_SEL]) begin
                        cursor <= cursor + 2'd1;
                    end else if (press[BTN_INC] && !press[BTN_DEC]) begin
                        digits[cursor] <= (digits[cursor] == 4'd9) ? 4'd0 : digits[cursor] + 4'd1;
                    end else if (press[BTN_DEC] && !press[BTN_INC]) begin
                        digits[cursor] <= (digits[cursor] == 4'd0) ? 4'd9 : digits[cursor] - 4'd1;
                    end
                end
                CONV: begin
                    // Horner fold, thousands first; max 9999 so 16 bits never overflow
                    acc <= acc * 16'd10 + {12'd0, digits[idx]};
                    idx <= idx - 2'd1;
                    if (idx == 2'd0)
                        state <= CLAMP;
                end
                CLAMP: begin
                    if (acc > MAX_V) begin
                        value_q   <= MAX_V;
                        clamped_q <= 1'b1;
                    end else if (below_min) begin
                        value_q   <= MIN_V;
                        clamped_q <= 1'b1;
                    end else begin
                        value_q   <= acc;
                        clamped_q <= 1'b0;
                    end
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.digits_bcd    = digits;
    assign bus.cursor        = cursor;
    assign bus.busy          = busy_q;
    assign bus.value_out     = value_q;
    assign bus.value_valid   = valid_q;
    assign bus.value_clamped = clamped_q;

endmodule

// File: tb/tb_decimal_value_entry.sv
// Bench for decimal_value_entry: two instances (default and 500..2500 clamp)
// share one button stream and are compared every cycle against a digit model.
module tb_decimal_value_entry;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decimal_value_entry_if ifa ();
    decimal_value_entry_if ifb ();

    decimal_value_entry u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    decimal_value_entry #(
        .MAX_VALUE     (2500),
        .MIN_VALUE     (500),
        .DEFAULT_VALUE (1500)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain decimal digits, cursor, and a countdown to publish
    int md[4];
    int mcur;
    bit mprev[4];
    int mcnt;
    int mval[2];
    bit mclamp[2];
    bit mvalid;
    int maxv[2];
    int minv[2];

    int busy_cnt;
    int vcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_bcd();
        return 32'(md[3] * 4096 + md[2] * 256 + md[1] * 16 + md[0]);
    endfunction

    task automatic model_reset();
        md[3] = 1; md[2] = 5; md[1] = 0; md[0] = 0;
        mcur = 0;
        mcnt = 0;
        mvalid = 1'b0;
        for (int k = 0; k < 4; k++) mprev[k] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mval[k]   = 1500;
            mclamp[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit r, input bit t, input bit s, input bit i,
                              input bit d, input bit c);
        bit btn[4];
        bit pr[4];
        int v;
        if (!r) begin
            model_reset();
            return;
        end
        btn[0] = s; btn[1] = i; btn[2] = d; btn[3] = c;
        for (int k = 0; k < 4; k++) pr[k] = t && btn[k] && !mprev[k];
        mvalid = 1'b0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                v = md[3] * 1000 + md[2] * 100 + md[1] * 10 + md[0];
                for (int k = 0; k < 2; k++) begin
                    if (v > maxv[k])      begin mval[k] = maxv[k]; mclamp[k] = 1'b1; end
                    else if (v < minv[k]) begin mval[k] = minv[k]; mclamp[k] = 1'b1; end
                    else                  begin mval[k] = v;       mclamp[k] = 1'b0; end
                end
                mvalid = 1'b1;
            end
        end else if (t) begin
            if (pr[3])                mcnt = 5;
            else if (pr[0])           mcur = (mcur + 1) % 4;
            else if (pr[1] && !pr[2]) md[mcur] = (md[mcur] + 1) % 10;
            else if (pr[2] && !pr[1]) md[mcur] = (md[mcur] + 9) % 10;
        end
        if (t) for (int k = 0; k < 4; k++) mprev[k] = btn[k];
    endtask

    task automatic compare_all();
        chk("a_digits",  ifa.digits_bcd,    model_bcd());
        chk("a_cursor",  ifa.cursor,        mcur);
        chk("a_busy",    ifa.busy,          mcnt > 0);
        chk("a_valid",   ifa.value_valid,   mvalid);
        chk("a_value",   ifa.value_out,     mval[0]);
        chk("a_clamped", ifa.value_clamped, mclamp[0]);
        chk("b_digits",  ifb.digits_bcd,    model_bcd());
        chk("b_cursor",  ifb.cursor,        mcur);
        chk("b_busy",    ifb.busy,          mcnt > 0);
        chk("b_valid",   ifb.value_valid,   mvalid);
        chk("b_value",   ifb.value_out,     mval[1]);
        chk("b_clamped", ifb.value_clamped, mclamp[1]);
    endtask

    task automatic step(input bit t, input bit s, input bit i, input bit d,
                        input bit c, input bit r = 1'b1);
        @(negedge clk);
        rst_n = r;
        ifa.tick = t; ifa.btn_sel = s; ifa.btn_inc = i; ifa.btn_dec = d; ifa.btn_commit = c;
        ifb.tick = t; ifb.btn_sel = s; ifb.btn_inc = i; ifb.btn_dec = d; ifb.btn_commit = c;
        @(posedge clk);
        model_edge(r, t, s, i, d, c);
        #1;
        compare_all();
        if (ifa.busy === 1'b1) busy_cnt++;
        if (ifa.value_valid === 1'b1) vcnt++;
    endtask

    task automatic press(input bit s, input bit i, input bit d, input bit c);
        step(1'b1, s, i, d, c);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic commit_seq();
        busy_cnt = 0;
        vcnt = 0;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_value(input int target);
        int tgt[4];
        tgt[0] = target % 10;
        tgt[1] = (target / 10) % 10;
        tgt[2] = (target / 100) % 10;
        tgt[3] = (target / 1000) % 10;
        for (int p = 0; p < 4; p++) begin
            while (mcur != p) press(1'b1, 1'b0, 1'b0, 1'b0);
            while (md[p] != tgt[p]) press(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        maxv[0] = 9999; minv[0] = 0;
        maxv[1] = 2500; minv[1] = 500;
        model_reset();
        ifa.tick = 0; ifa.btn_sel = 0; ifa.btn_inc = 0; ifa.btn_dec = 0; ifa.btn_commit = 0;
        ifb.tick = 0; ifb.btn_sel = 0; ifb.btn_inc = 0; ifb.btn_dec = 0; ifb.btn_commit = 0;

        // Reset state
        do_reset();
        chk("rst_digits", ifa.digits_bcd, 32'h1500);
        chk("rst_value",  ifa.value_out,  1500);
        chk("rst_busy",   ifa.busy,       0);

        // Edit and commit
        repeat (3) press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("edit_digits", ifa.digits_bcd, 32'h1523);
        commit_seq();
        chk("commit_value", ifa.value_out, 1523);
        chk("commit_clamp", ifa.value_clamped, 0);
        chk("busy_len", busy_cnt, 5);
        chk("valid_pulses", vcnt, 1);

        // Wrap without carry/borrow
        do_reset();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        chk("dec_wrap", ifa.digits_bcd, 32'h1509);
        repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (9) press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("inc_wrap", ifa.digits_bcd, 32'h0509);
        repeat (5) press(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sel_wrap", ifa.cursor, 0);

        // Clamping on the narrowed instance
        do_reset();
        set_value(9000);
        commit_seq();
        chk("clamp_hi_b", ifb.value_out, 2500);
        chk("clamp_hi_bf", ifb.value_clamped, 1);
        chk("clamp_hi_a", ifa.value_out, 9000);
        set_value(100);
        commit_seq();
        chk("clamp_lo_b", ifb.value_out, 500);
        chk("clamp_lo_bf", ifb.value_clamped, 1);
        chk("clamp_lo_a", ifa.value_out, 100);
        chk("clamp_lo_af", ifa.value_clamped, 0);

        // Held, between-tick, simultaneous, and busy presses
        do_reset();
        repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("held_inc", ifa.digits_bcd, 32'h1501);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("untick_inc", ifa.digits_bcd, 32'h1501);
        press(1'b0, 1'b1, 1'b1, 1'b0);
        chk("inc_dec", ifa.digits_bcd, 32'h1501);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_inc", ifa.digits_bcd, 32'h1501);
        chk("busy_val", ifa.value_out, 1501);

        // Reset mid-conversion
        do_reset();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vcnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_valid", vcnt, 0);
        chk("abort_value", ifa.value_out, 1500);
        chk("abort_digits", ifa.digits_bcd, 32'h1500);
        chk("abort_busy", ifa.busy, 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 299) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
